// File: rtl/multiword_adder_pkg.sv
// rtl/multiword_adder_pkg.sv - shared types and sizing helpers for the multiword adder sequencer
package multiword_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word index needs at least one bit even when WORDS == 1.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/multiword_adder_seq_if.sv
// rtl/multiword_adder_seq_if.sv - request/result handshake bundle for multiword_adder_seq
interface multiword_adder_seq_if #(
  parameter int N     = 8,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Overflow;

  modport master (
    output in_valid, A, B, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Overflow
  );

  modport slave (
    input  in_valid, A, B, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Overflow
  );

endinterface

// File: rtl/rca_slice.sv
// rtl/rca_slice.sv - combinational N-bit ripple-carry slice with carry-in, carry-out and signed overflow
module rca_slice #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];
  assign ovf  = c[N-1] ^ c[N];

endmodule

// File: rtl/multiword_adder_seq.sv
// rtl/multiword_adder_seq.sv - WORDS*N-bit signed add/sub over one time-multiplexed N-bit slice
// Optional signed saturation of the result: define MULTIWORD_ADDER_SAT_EN.
module multiword_adder_seq
  import multiword_adder_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  multiword_adder_seq_if.slave bus
);

  localparam int W  = N * WORDS;
  localparam int IW = idx_width(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          ovf_q;
  logic          valid_q;

  logic [N-1:0]  s_sum;
  logic          s_cout;
  logic          s_ovf;

  rca_slice #(.N(N)) u_slice (
    .a    (a_q[idx*N +: N]),
    .b    (b_q[idx*N +: N]),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout),
    .ovf  (s_ovf)
  );

`ifdef MULTIWORD_ADDER_SAT_EN
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Subtraction is A + ~B + 1, the +1 entering as the initial carry.
          if (bus.in_valid) begin
            a_q   <= bus.A;
            b_q   <= bus.Sub ? ~bus.B : bus.B;
            carry <= bus.Sub;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[idx*N +: N] <= s_sum;
          carry             <= s_cout;
          if (idx == LAST) begin
            cout_q  <= s_cout;
            ovf_q   <= s_ovf;
            valid_q <= 1'b1;
            state   <= DONE;
`ifdef MULTIWORD_ADDER_SAT_EN
            if (s_ovf) sum_q <= a_q[W-1] ? SAT_NEG : SAT_POS;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = valid_q;
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.Overflow  = ovf_q;

endmodule
